// File: rtl/mctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state codes,
// opcode/funct constants, ALU operation codes and datapath mux selects.
package mctrl_pkg;

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_WB_LW   = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EX_R    = 4'd6,
    S_WB_R    = 4'd7,
    S_EX_BEQ  = 4'd8,
    S_EX_J    = 4'd9,
    S_EX_I    = 4'd10,
    S_WB_I    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic       SRCA_PC = 1'b0;
  localparam logic       SRCA_RS = 1'b1;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       reg_write;
    logic       alu_src_a;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       illegal_inst;
    logic       exc_ovf;
  } ctrl_t;

endpackage

// File: rtl/multi_ctrl_alu_op_dec.sv
// R-type funct decoder: ALU operation, funct legality, and whether the
// operation is one that can raise a signed-overflow exception.
module alu_op_dec
  import mctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       legal,
  output logic       ovf_capable
);

  always_comb begin
    alu_op      = ALU_AND;
    legal       = 1'b1;
    ovf_capable = 1'b0;
    case (funct)
      FN_ADD: begin
        alu_op      = ALU_ADD;
        ovf_capable = 1'b1;
      end
      FN_SUB: begin
        alu_op      = ALU_SUB;
        ovf_capable = 1'b1;
      end
      FN_AND: alu_op = ALU_AND;
      FN_OR:  alu_op = ALU_OR;
      FN_XOR: alu_op = ALU_XOR;
      FN_NOR: alu_op = ALU_NOR;
      FN_SLT: alu_op = ALU_SLT;
      FN_SRL: alu_op = ALU_SRL;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_ctrl.sv
// Multi-cycle MIPS control unit: one state register plus a combinational
// Moore next-state/output process; outputs are forced low during reset.
module multi_ctrl
  import mctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Inst,
  input  logic        MIO_ready,
  input  logic        zero,
  input  logic        overflow,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        Branch,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic [2:0]  ALU_operation,
  output logic [3:0]  state,
  output logic        illegal_inst,
  output logic        exc_ovf
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [2:0] r_alu_op;
  logic       r_legal;
  logic       r_ovf_capable;
  logic       unused_inst_bits;
  logic       unused_zero;

  state_t state_q;
  state_t state_d;
  logic   ovf_q;
  logic   ovf_d;
  ctrl_t  ctrl;
  ctrl_t  ctrl_out;

  assign op    = Inst[31:26];
  assign funct = Inst[5:0];

  // The branch decision is taken in the datapath from zero, not here.
  assign unused_inst_bits = ^Inst[25:6];
  assign unused_zero      = zero;

  alu_op_dec u_alu_op_dec (
    .funct       (funct),
    .alu_op      (r_alu_op),
    .legal       (r_legal),
    .ovf_capable (r_ovf_capable)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IF;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    ovf_d   = 1'b0;
    case (state_q)
      S_IF: begin
        ctrl.mem_read  = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.ir_write  = MIO_ready;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_SEQ;
        ctrl.pc_write  = 1'b1;
        if (MIO_ready)
          state_d = S_ID;
      end
      S_ID: begin
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
        case (op)
          OP_RTYPE: begin
            if (r_legal) begin
              state_d = S_EX_R;
            end else begin
              state_d           = S_IF;
              ctrl.illegal_inst = 1'b1;
            end
          end
          OP_LW, OP_SW:     state_d = S_MEM_ADR;
          OP_BEQ:           state_d = S_EX_BEQ;
          OP_J:             state_d = S_EX_J;
          OP_ADDI, OP_SLTI: state_d = S_EX_I;
          default: begin
            state_d           = S_IF;
            ctrl.illegal_inst = 1'b1;
          end
        endcase
      end
      S_MEM_ADR: begin
        ctrl.alu_src_a = SRCA_RS;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        state_d        = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        if (MIO_ready)
          state_d = S_WB_LW;
      end
      S_WB_LW: begin
        ctrl.reg_dst    = REGDST_RT;
        ctrl.mem_to_reg = M2R_MDR;
        ctrl.reg_write  = 1'b1;
        state_d         = S_IF;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        if (MIO_ready)
          state_d = S_IF;
      end
      S_EX_R: begin
        ctrl.alu_src_a = SRCA_RS;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = r_alu_op;
        ovf_d          = overflow & r_ovf_capable;
        state_d        = S_WB_R;
      end
      // A flagged overflow suppresses the write-back and raises the exception.
      S_WB_R: begin
        ctrl.reg_dst    = REGDST_RD;
        ctrl.mem_to_reg = M2R_ALU;
        ctrl.reg_write  = ~ovf_q;
        ctrl.exc_ovf    = ovf_q;
        state_d         = S_IF;
      end
      S_EX_BEQ: begin
        ctrl.alu_src_a     = SRCA_RS;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_source     = PCSRC_BR;
        ctrl.pc_write_cond = 1'b1;
        ctrl.branch        = 1'b1;
        state_d            = S_IF;
      end
      S_EX_J: begin
        ctrl.pc_source = PCSRC_JMP;
        ctrl.pc_write  = 1'b1;
        state_d        = S_IF;
      end
      S_EX_I: begin
        ctrl.alu_src_a = SRCA_RS;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
        ovf_d          = overflow & (op == OP_ADDI);
        state_d        = S_WB_I;
      end
      S_WB_I: begin
        ctrl.reg_dst    = REGDST_RT;
        ctrl.mem_to_reg = M2R_ALU;
        ctrl.reg_write  = ~ovf_q;
        ctrl.exc_ovf    = ovf_q;
        state_d         = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  assign ctrl_out = reset ? ctrl : '0;

  assign MemRead       = ctrl_out.mem_read;
  assign MemWrite      = ctrl_out.mem_write;
  assign IorD          = ctrl_out.iord;
  assign IRWrite       = ctrl_out.ir_write;
  assign RegWrite      = ctrl_out.reg_write;
  assign ALUSrcA       = ctrl_out.alu_src_a;
  assign PCWrite       = ctrl_out.pc_write;
  assign PCWriteCond   = ctrl_out.pc_write_cond;
  assign Branch        = ctrl_out.branch;
  assign RegDst        = ctrl_out.reg_dst;
  assign MemtoReg      = ctrl_out.mem_to_reg;
  assign ALUSrcB       = ctrl_out.alu_src_b;
  assign PCSource      = ctrl_out.pc_source;
  assign ALU_operation = ctrl_out.alu_op;
  assign illegal_inst  = ctrl_out.illegal_inst;
  assign exc_ovf       = ctrl_out.exc_ovf;
  assign state         = state_q;

endmodule

// File: tb/tb_multi_ctrl.sv
// Self-checking bench for multi_ctrl: per-cycle expected output vectors are
// queued as stimulus is driven and compared when sampled on the falling edge.
module tb_multi_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       reg_write;
    logic       alu_src_a;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       illegal_inst;
    logic       exc_ovf;
  } outs_t;

  logic        clk;
  logic        reset;
  logic [31:0] Inst;
  logic        MIO_ready;
  logic        zero;
  logic        overflow;
  logic        MemRead, MemWrite, IorD, IRWrite, RegWrite, ALUSrcA;
  logic        PCWrite, PCWriteCond, Branch;
  logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
  logic [2:0]  ALU_operation;
  logic [3:0]  state;
  logic        illegal_inst, exc_ovf;

  outs_t obs;
  outs_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  multi_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .Inst          (Inst),
    .MIO_ready     (MIO_ready),
    .zero          (zero),
    .overflow      (overflow),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .IorD          (IorD),
    .IRWrite       (IRWrite),
    .RegWrite      (RegWrite),
    .ALUSrcA       (ALUSrcA),
    .PCWrite       (PCWrite),
    .PCWriteCond   (PCWriteCond),
    .Branch        (Branch),
    .RegDst        (RegDst),
    .MemtoReg      (MemtoReg),
    .ALUSrcB       (ALUSrcB),
    .PCSource      (PCSource),
    .ALU_operation (ALU_operation),
    .state         (state),
    .illegal_inst  (illegal_inst),
    .exc_ovf       (exc_ovf)
  );

  assign obs = {state, MemRead, MemWrite, IorD, IRWrite, RegWrite, ALUSrcA,
                PCWrite, PCWriteCond, Branch, RegDst, MemtoReg, ALUSrcB,
                PCSource, ALU_operation, illegal_inst, exc_ovf};

  always #5 clk = ~clk;

  // Expected Moore outputs of each state with default ALU op and IRWrite=0.
  function automatic outs_t base(input logic [3:0] st);
    outs_t e;
    e    = '0;
    e.st = st;
    case (st)
      4'd0: begin
        e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.alu_op = 3'b010; e.pc_write = 1'b1;
      end
      4'd1: begin e.alu_src_b = 2'b11; e.alu_op = 3'b010; end
      4'd2: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 3'b010; end
      4'd3: begin e.mem_read = 1'b1; e.iord = 1'b1; end
      4'd4: begin e.mem_to_reg = 2'b01; e.reg_write = 1'b1; end
      4'd5: begin e.mem_write = 1'b1; e.iord = 1'b1; end
      4'd6: begin e.alu_src_a = 1'b1; end
      4'd7: begin e.reg_dst = 2'b01; e.reg_write = 1'b1; end
      4'd8: begin
        e.alu_src_a = 1'b1; e.alu_op = 3'b110; e.pc_source = 2'b01;
        e.pc_write_cond = 1'b1; e.branch = 1'b1;
      end
      4'd9: begin e.pc_source = 2'b10; e.pc_write = 1'b1; end
      4'd10: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 3'b010; end
      4'd11: begin e.reg_write = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic checkOutput(input string tag, input outs_t observed, input outs_t expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (state got %0d exp %0d)",
               tag, observed, expected, observed.st, expected.st);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare at negedge.
  task automatic applyStimulus(input string tag, input logic [31:0] inst,
                               input logic mio, input logic ovf, input logic zr,
                               input outs_t expected);
    outs_t e;
    Inst      = inst;
    MIO_ready = mio;
    overflow  = ovf;
    zero      = zr;
    exp_q.push_back(expected);
    @(negedge clk);
    e = exp_q.pop_front();
    checkOutput(tag, obs, e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [31:0] inst, input int waits);
    outs_t e;
    for (int i = 0; i < waits; i++)
      applyStimulus({tag, "_if_wait"}, inst, 1'b0, 1'b0, 1'b0, base(4'd0));
    e = base(4'd0);
    e.ir_write = 1'b1;
    applyStimulus({tag, "_if"}, inst, 1'b1, 1'b0, 1'b0, e);
  endtask

  task automatic decode(input string tag, input logic [31:0] inst, input logic ill);
    outs_t e;
    e = base(4'd1);
    e.illegal_inst = ill;
    applyStimulus({tag, "_id"}, inst, 1'b1, 1'b0, 1'b0, e);
  endtask

  task automatic run_rtype(input string tag, input logic [5:0] fn,
                           input logic [2:0] alu, input logic ovf, input logic exc);
    logic [31:0] inst;
    outs_t e;
    inst = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, fn};
    fetch(tag, inst, 0);
    decode(tag, inst, 1'b0);
    e = base(4'd6);
    e.alu_op = alu;
    applyStimulus({tag, "_ex"}, inst, 1'b1, ovf, 1'b0, e);
    e = base(4'd7);
    if (exc) begin
      e.reg_write = 1'b0;
      e.exc_ovf   = 1'b1;
    end
    applyStimulus({tag, "_wb"}, inst, 1'b1, 1'b0, 1'b0, e);
  endtask

  task automatic run_itype(input string tag, input logic [31:0] inst,
                           input logic [2:0] alu, input logic ovf, input logic exc);
    outs_t e;
    fetch(tag, inst, 0);
    decode(tag, inst, 1'b0);
    e = base(4'd10);
    e.alu_op = alu;
    applyStimulus({tag, "_ex"}, inst, 1'b1, ovf, 1'b0, e);
    e = base(4'd11);
    if (exc) begin
      e.reg_write = 1'b0;
      e.exc_ovf   = 1'b1;
    end
    applyStimulus({tag, "_wb"}, inst, 1'b1, 1'b0, 1'b0, e);
  endtask

  typedef struct packed {
    logic [5:0] fn;
    logic [2:0] alu;
    logic       ovf;
    logic       exc;
  } rvec_t;

  rvec_t rtab[8];

  initial begin
    clk       = 1'b0;
    reset     = 1'b1;
    Inst      = 32'h0;
    MIO_ready = 1'b0;
    zero      = 1'b0;
    overflow  = 1'b0;

    rtab[0] = '{6'h20, 3'b010, 1'b1, 1'b1};
    rtab[1] = '{6'h22, 3'b110, 1'b1, 1'b1};
    rtab[2] = '{6'h24, 3'b000, 1'b1, 1'b0};
    rtab[3] = '{6'h25, 3'b001, 1'b0, 1'b0};
    rtab[4] = '{6'h26, 3'b011, 1'b0, 1'b0};
    rtab[5] = '{6'h27, 3'b100, 1'b1, 1'b0};
    rtab[6] = '{6'h2A, 3'b111, 1'b0, 1'b0};
    rtab[7] = '{6'h02, 3'b101, 1'b0, 1'b0};

    // Reset: everything but state low, even with MIO_ready high in IF.
    #1 reset = 1'b0;
    #1 checkOutput("reset_async", obs, outs_t'(0));
    MIO_ready = 1'b1;
    Inst      = $urandom;
    @(negedge clk);
    checkOutput("reset_held", obs, outs_t'(0));
    @(posedge clk);
    #1 reset = 1'b1;

    // add $3,$1,$2 then the rest of the R-type functs.
    run_rtype("add", 6'h20, 3'b010, 1'b0, 1'b0);
    foreach (rtab[i])
      run_rtype($sformatf("r_fn%02h", rtab[i].fn), rtab[i].fn, rtab[i].alu,
                rtab[i].ovf, rtab[i].exc);

    // lw with a fetch wait and a 3-cycle memory wait in MEM_RD.
    fetch("lw", 32'h8C220004, 2);
    decode("lw", 32'h8C220004, 1'b0);
    applyStimulus("lw_adr", 32'h8C220004, 1'b1, 1'b0, 1'b0, base(4'd2));
    for (int i = 0; i < 3; i++)
      applyStimulus("lw_rd_wait", 32'h8C220004, 1'b0, 1'b0, 1'b0, base(4'd3));
    applyStimulus("lw_rd", 32'h8C220004, 1'b1, 1'b0, 1'b0, base(4'd3));
    applyStimulus("lw_wb", 32'h8C220004, 1'b1, 1'b0, 1'b0, base(4'd4));

    // beq taken and not taken: identical control outputs.
    for (int z = 1; z >= 0; z--) begin
      fetch("beq", 32'h10220003, 0);
      decode("beq", 32'h10220003, 1'b0);
      applyStimulus($sformatf("beq_ex_z%0d", z), 32'h10220003, 1'b1, 1'b0,
                    1'(z), base(4'd8));
    end

    fetch("j", 32'h08000010, 0);
    decode("j", 32'h08000010, 1'b0);
    applyStimulus("j_ex", 32'h08000010, 1'b1, 1'b0, 1'b0, base(4'd9));

    run_itype("addi_ovf", 32'h20220001, 3'b010, 1'b1, 1'b1);
    run_itype("addi", 32'h20220001, 3'b010, 1'b0, 1'b0);
    run_itype("slti_ovf", 32'h28220001, 3'b111, 1'b1, 1'b0);

    // Illegal opcode and illegal funct both fall back to IF.
    fetch("ill_op", 32'hFC000000, 0);
    decode("ill_op", 32'hFC000000, 1'b1);
    fetch("ill_fn", 32'h0000003F, 0);
    decode("ill_fn", 32'h0000003F, 1'b1);

    // sw held in MEM_WR, then reset asserted mid-wait without a clock edge.
    fetch("sw", 32'hAC220004, 0);
    decode("sw", 32'hAC220004, 1'b0);
    applyStimulus("sw_adr", 32'hAC220004, 1'b1, 1'b0, 1'b0, base(4'd2));
    for (int i = 0; i < 2; i++)
      applyStimulus("sw_wr_wait", 32'hAC220004, 1'b0, 1'b0, 1'b0, base(4'd5));
    #2 checkOutput("sw_wr_pre_reset", obs, base(4'd5));
    reset = 1'b0;
    #1 checkOutput("sw_reset_async", obs, outs_t'(0));
    MIO_ready = 1'b1;
    #1 checkOutput("sw_reset_ready", obs, outs_t'(0));
    @(posedge clk);
    #1 reset = 1'b1;

    fetch("post_reset", 32'h00221820, 0);
    decode("post_reset", 32'h00221820, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
